data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Byte-addressed data memory that answers requests from the EXE/MEM pipeline register: address, write data, access size and load/store flag.
- Inserts a configurable number of wait states, drives a busy stall back to the pipeline and returns load data with a one-cycle done pulse.
- Stores data big-endian; flags misaligned or out-of-range accesses instead of performing them.

Parameters:
- DEPTH, 256, memory size in bytes; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 1, extra wait states before each access (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  input  1  request strobe, sampled only in IDLE.
- mem_load  input  1  1 = load (read), 0 = store (write).
- mem_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error).
- mem_addr  input  32  byte address.
- mem_wdata  input  32  store data; the byte uses [7:0], the halfword uses [15:0].
- mem_rdata  output  32  load result, zero-extended.
- mem_done  output  1  one-cycle pulse when a request completes.
- mem_busy  output  1  high from request acceptance until completion; the pipeline stalls on it.
- mem_err  output  1  one-cycle pulse together with mem_done for a rejected access.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, wait counter=0, captured request cleared.
  - mem_rdata=0, mem_done=0, mem_busy=0, mem_err=0.
  - Memory array contents are not affected by reset.
  - Reset asserted mid-access aborts the access with no write and no done pulse.
- All outputs are registered.
- The FSM has three states: IDLE, WAIT, ACCESS.
- IDLE:
  - mem_done and mem_err return to 0 unless set on this edge.
  - If mem_req=1, capture load, size, addr and wdata, and set mem_busy<=1.
  - Next state is ACCESS if WAIT_CYCLES=0; otherwise WAIT with cnt<=WAIT_CYCLES-1.
- WAIT:
  - If cnt=0, go to ACCESS; otherwise cnt<=cnt-1.
  - Inputs are ignored in this state.
- ACCESS: on the edge leaving the state, go to IDLE with mem_busy<=0 and mem_done<=1.
  - Error check: size=11; halfword with addr[0]=1; word with addr[1:0]≠0; or addr+bytes-1 ≥ DEPTH.
  - On error: mem_err<=1, mem_rdata<=0, no memory write.
  - Store byte: mem[a]<=wdata[7:0].
  - Store halfword: mem[a]<=wdata[15:8], mem[a+1]<=wdata[7:0].
  - Store word: mem[a..a+3]<=wdata[31:24], [23:16], [15:8], [7:0].
  - On a store, mem_rdata is unchanged.
  - Load: mem_rdata<={24'b0,mem[a]}, {16'b0,mem[a],mem[a+1]}, or {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- Latency: a request sampled at edge E produces mem_done high after edge E+WAIT_CYCLES+1. mem_busy is high for exactly WAIT_CYCLES+1 cycles.
- mem_req while busy (WAIT/ACCESS) is ignored; it is not queued.
- mem_req high in the cycle where mem_done is high (FSM back in IDLE) is accepted; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Input changes after capture do not affect the in-flight access.
- mem_rdata holds its last load value until the next successful load, error or reset.

Test Plan:
- Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF @0x10, then load word @0x10. Required: rdata=0xDEADBEEF; done high 2 edges after each accepted request; busy high for exactly 2 cycles.
- Big-endian byte/halfword: after the word above, load byte @0x11 -> 0x000000AD; load halfword @0x12 -> 0x0000BEEF. Store byte 0x5A @0x13, then load word @0x10 -> 0xDEADBE5A.
- Misalignment/range:
  - Load word @0x12 -> done+err, rdata=0.
  - Store halfword @0x21 -> err, and a subsequent word load @0x20 is unchanged.
  - Load word @DEPTH-2 -> err.
  - mem_size=11 -> err.
- Busy ignore / back-to-back: hold mem_req=1 continuously with changing addresses. Only requests sampled in IDLE are executed. A request coinciding with the done cycle starts the next access with no gap cycle.
- Reset mid-access: issue store 0x11223344 @0x40 with WAIT_CYCLES=3 and assert reset during WAIT. Required: busy, done and err drop to 0 immediately (asynchronously). A later load @0x40 returns the old contents.
- WAIT_CYCLES=0 build: load completes with done one edge after acceptance and busy high for one cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory for the MEM stage: captures one request,
// inserts WAIT_CYCLES wait states, then performs or rejects the access.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_load,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        ld_p0;
  logic [1:0]  size_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [7:0]  mem [DEPTH];

  logic          acc_err;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   rd_val;

  // Rejects reserved size, misalignment, and any byte beyond the array end.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] last;
    logic        bad;
    bad  = 1'b0;
    last = {1'b0, addr};
    case (size)
      2'b00: last = {1'b0, addr};
      2'b01: begin bad = addr[0];          last = {1'b0, addr} + 33'd1; end
      2'b10: begin bad = (addr[1:0] != 2'b00); last = {1'b0, addr} + 33'd3; end
      default: bad = 1'b1;
    endcase
    return bad || (last >= 33'(DEPTH));
  endfunction

  always_comb begin
    acc_err = access_err(size_p0, addr_p0);
    a0      = addr_p0[AW-1:0];
    a1      = a0 + AW'(1);
    a2      = a0 + AW'(2);
    a3      = a0 + AW'(3);
    case (size_p0)
      2'b00:   rd_val = {24'b0, mem[a0]};
      2'b01:   rd_val = {16'b0, mem[a0], mem[a1]};
      default: rd_val = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (mem_req) state_n = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd0) state_n = S_ACCESS;
      S_ACCESS: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Capture stage (IDLE) and completion stage (ACCESS)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      ld_p0     <= 1'b0;
      size_p0   <= 2'b00;
      addr_p0   <= 32'd0;
      wdata_p0  <= 32'd0;
      mem_rdata <= 32'd0;
      mem_done  <= 1'b0;
      mem_busy  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_done <= 1'b0;
          mem_err  <= 1'b0;
          if (mem_req) begin
            ld_p0    <= mem_load;
            size_p0  <= mem_size;
            addr_p0  <= mem_addr;
            wdata_p0 <= mem_wdata;
            mem_busy <= 1'b1;
            cnt      <= WAIT_INIT;
          end
        end
        S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        S_ACCESS: begin
          mem_busy <= 1'b0;
          mem_done <= 1'b1;
          if (acc_err) begin
            mem_err   <= 1'b1;
            mem_rdata <= 32'd0;
          end else if (ld_p0) begin
            mem_rdata <= rd_val;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is never reset; a store only lands on the edge that leaves ACCESS.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && !ld_p0 && !acc_err) begin
      case (size_p0)
        2'b00: mem[a0] <= wdata_p0[7:0];
        2'b01: begin
          mem[a0] <= wdata_p0[15:8];
          mem[a1] <= wdata_p0[7:0];
        end
        default: begin
          mem[a0] <= wdata_p0[31:24];
          mem[a1] <= wdata_p0[23:16];
          mem[a2] <= wdata_p0[15:8];
          mem[a3] <= wdata_p0[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (WAIT_CYCLES 1, 3, 0) against a byte-array model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic        ld    [3];
  logic [1:0]  sz    [3];
  logic [31:0] ad    [3];
  logic [31:0] wd    [3];
  logic [31:0] rd_o  [3];
  logic        done_o[3];
  logic        busy_o[3];
  logic        err_o [3];

  int          wc[3] = '{1, 3, 0};
  logic [7:0]  ref_mem[3][DEPTH];
  logic [31:0] ref_rd[3];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst[0]), .mem_req(req[0]), .mem_load(ld[0]), .mem_size(sz[0]),
    .mem_addr(ad[0]), .mem_wdata(wd[0]), .mem_rdata(rd_o[0]), .mem_done(done_o[0]),
    .mem_busy(busy_o[0]), .mem_err(err_o[0]));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst[1]), .mem_req(req[1]), .mem_load(ld[1]), .mem_size(sz[1]),
    .mem_addr(ad[1]), .mem_wdata(wd[1]), .mem_rdata(rd_o[1]), .mem_done(done_o[1]),
    .mem_busy(busy_o[1]), .mem_err(err_o[1]));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .reset(rst[2]), .mem_req(req[2]), .mem_load(ld[2]), .mem_size(sz[2]),
    .mem_addr(ad[2]), .mem_wdata(wd[2]), .mem_rdata(rd_o[2]), .mem_done(done_o[2]),
    .mem_busy(busy_o[2]), .mem_err(err_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: big-endian byte array, access legal iff aligned and fully inside DEPTH.
  function automatic void model(input int d, input bit load, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic e, output logic [31:0] r);
    int n;
    longint unsigned a;
    logic [31:0] acc;
    n = 1 << size;
    a = addr;
    e = (size == 2'b11) || (a % n != 0) || (a + n > DEPTH);
    if (e) ref_rd[d] = 32'd0;
    else if (load) begin
      acc = 32'd0;
      for (int i = 0; i < n; i++) acc = (acc << 8) | {24'd0, ref_mem[d][a + i]};
      ref_rd[d] = acc;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[d][a + i] = 8'(wdata >> (8 * (n - 1 - i)));
    end
    r = ref_rd[d];
  endfunction

  // Issue one request from the done/idle cycle and follow it to completion.
  task automatic do_req(input int d, input bit load, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] obs_rd, output logic obs_err);
    int lat;
    bit busy_ok;
    logic [31:0] exp_rd;
    logic exp_err;
    model(d, load, size, addr, wdata, exp_err, exp_rd);
    req[d] = 1'b1; ld[d] = load; sz[d] = size; ad[d] = addr; wd[d] = wdata;
    @(posedge clk); #1;
    req[d] = 1'b0; ld[d] = ~load; ad[d] = $urandom; wd[d] = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (1) begin
      if (busy_o[d] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done_o[d] === 1'b1 || lat > 40) break;
    end
    check("latency", 32'(lat), 32'(wc[d] + 1));
    check("busy_window", {31'd0, busy_ok && (busy_o[d] === 1'b0)}, 32'd1);
    check("err", {31'd0, err_o[d]}, {31'd0, exp_err});
    check("rdata", rd_o[d], exp_rd);
    obs_rd = rd_o[d];
    obs_err = err_o[d];
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    logic [31:0] pres[12];
    logic [31:0] er;
    logic ee;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; ld[d] = 1'b0; sz[d] = 2'b00; ad[d] = '0; wd[d] = '0;
      ref_rd[d] = 32'd0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      check("rst_rdata", rd_o[d], 32'd0);
      check("rst_flags", {29'd0, done_o[d], busy_o[d], err_o[d]}, 32'd0);
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;

    // Fill the W=1 build with random words so every later load is defined.
    for (int i = 0; i < 64; i++) do_req(0, 1'b0, 2'b10, 32'(4 * i), $urandom, r, e);

    do_req(0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, r, e);
    @(posedge clk); #1;
    check("done_pulse", {30'd0, done_o[0], err_o[0]}, 32'd0);
    do_req(0, 1'b1, 2'b10, 32'h10, 32'h0, r, e);
    check("ld_word", r, 32'hDEADBEEF);
    do_req(0, 1'b1, 2'b00, 32'h11, 32'h0, r, e);
    check("ld_byte", r, 32'h000000AD);
    do_req(0, 1'b1, 2'b01, 32'h12, 32'h0, r, e);
    check("ld_half", r, 32'h0000BEEF);
    do_req(0, 1'b0, 2'b00, 32'h13, 32'h0000005A, r, e);
    check("st_keeps_rdata", r, 32'h0000BEEF);
    do_req(0, 1'b1, 2'b10, 32'h10, 32'h0, r, e);
    check("ld_word2", r, 32'hDEADBE5A);
    do_req(0, 1'b1, 2'b10, 32'h12, 32'h0, r, e);
    check("misalign_word", {r[30:0], e}, 32'd1);
    do_req(0, 1'b1, 2'b10, 32'h20, 32'h0, er, ee);
    do_req(0, 1'b0, 2'b01, 32'h21, 32'hFFFF, r, e);
    check("misalign_half_err", {31'd0, e}, 32'd1);
    do_req(0, 1'b1, 2'b10, 32'h20, 32'h0, r, e);
    check("misalign_half_nowrite", r, er);
    do_req(0, 1'b1, 2'b10, 32'(DEPTH - 2), 32'h0, r, e);
    check("range_err", {31'd0, e}, 32'd1);
    do_req(0, 1'b1, 2'b11, 32'h0, 32'h0, r, e);
    check("size11_err", {31'd0, e}, 32'd1);

    // Hold mem_req with a new word address each cycle; only IDLE samples execute.
    @(posedge clk); #1;
    req[0] = 1'b1; ld[0] = 1'b1; sz[0] = 2'b10;
    for (int i = 0; i < 12; i++) begin
      ad[0] = 32'(4 * i + 64);
      pres[i] = ad[0];
      @(posedge clk); #1;
      check("hold_done", {30'd0, done_o[0], busy_o[0]}, (i % 3 == 2) ? 32'd2 : 32'd1);
      if (i % 3 == 2) begin
        model(0, 1'b1, 2'b10, pres[i - 2], 32'd0, ee, er);
        check("hold_rdata", rd_o[0], er);
      end
    end
    req[0] = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(240, 270)) : 32'($urandom_range(0, 255));
      do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, r, e);
    end

    // Reset during WAIT on the W=3 build aborts the store.
    do_req(1, 1'b0, 2'b10, 32'h40, 32'hA5A5A5A5, r, e);
    do_req(1, 1'b1, 2'b10, 32'h40, 32'h0, r, e);
    check("w3_load", r, 32'hA5A5A5A5);
    req[1] = 1'b1; ld[1] = 1'b0; sz[1] = 2'b10; ad[1] = 32'h40; wd[1] = 32'h11223344;
    @(posedge clk); #1;
    req[1] = 1'b0;
    check("w3_busy", {31'd0, busy_o[1]}, 32'd1);
    #2 rst[1] = 1'b1;
    #1;
    check("async_rst_flags", {29'd0, done_o[1], busy_o[1], err_o[1]}, 32'd0);
    check("async_rst_rdata", rd_o[1], 32'd0);
    ref_rd[1] = 32'd0;
    #3 rst[1] = 1'b0;
    @(posedge clk); #1;
    do_req(1, 1'b1, 2'b10, 32'h40, 32'h0, r, e);
    check("abort_nowrite", r, 32'hA5A5A5A5);

    // Zero-wait build.
    do_req(2, 1'b0, 2'b10, 32'h08, 32'h01020304, r, e);
    do_req(2, 1'b1, 2'b10, 32'h08, 32'h0, r, e);
    check("w0_word", r, 32'h01020304);
    do_req(2, 1'b1, 2'b00, 32'h0B, 32'h0, r, e);
    check("w0_byte", r, 32'h00000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
